// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EXEC,
    HALT
  } fetch_state_t;

  // RV32 addi x0,x0,0
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction and feeds the core.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned next_pc halts fetch and raises fetch_fault.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [31:0]          imem_resp_data,
  output logic [31:0]          instruction,
  output logic [31:0]          pc,
  input  logic [31:0]          next_pc,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic                 fetch_fault
);

  fetch_state_t         state;
  logic [31:0]          pc_q;
  logic [31:0]          instr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                 fault_q;
`endif

  // Outputs decode the state register only, so reset clears them without a clock edge.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc_q;
  assign retire         = (state == EXEC);
  assign instruction    = (state == EXEC) ? instr_q : NOP_INSTR;
  assign pc             = pc_q;
  assign retired_count  = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_q;
`else
  assign fetch_fault    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) state <= REQ;
        end
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            instr_q <= imem_resp_data;
            state   <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
`ifdef FETCH_MISALIGN_TRAP_EN
          pc_q <= next_pc;
          if (next_pc[1:0] != 2'b00) begin
            fault_q <= 1'b1;
            state   <= HALT;
          end else begin
            state <= fetch_en ? REQ : IDLE;
          end
`else
          pc_q  <= next_pc & 32'hFFFF_FFFC;
          state <= fetch_en ? REQ : IDLE;
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
          state <= HALT;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a flag-based model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        retire;
  logic [31:0] retired_count;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instruction    (instruction),
    .pc             (pc),
    .next_pc        (next_pc),
    .retire         (retire),
    .retired_count  (retired_count),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is either wanted, awaiting data, or being executed; halted only after a trap.
  logic        m_want_req, m_await_data, m_executing, m_halted;
  logic [31:0] m_pc, m_word, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_want_req   <= 1'b0;
      m_await_data <= 1'b0;
      m_executing  <= 1'b0;
      m_halted     <= 1'b0;
      m_pc         <= 32'h0;
      m_word       <= NOP;
      m_cnt        <= 32'h0;
    end else if (m_executing) begin
      m_executing <= 1'b0;
      m_cnt       <= m_cnt + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc <= next_pc;
      if (next_pc % 4 != 0) m_halted <= 1'b1;
      else                  m_want_req <= fetch_en;
`else
      m_pc       <= next_pc - (next_pc % 4);
      m_want_req <= fetch_en;
`endif
    end else if (m_await_data) begin
      if (imem_resp_valid) begin
        m_word       <= imem_resp_data;
        m_await_data <= 1'b0;
        m_executing  <= 1'b1;
      end
    end else if (m_want_req) begin
      if (imem_req_ready) begin
        m_want_req   <= 1'b0;
        m_await_data <= 1'b1;
      end
    end else if (!m_halted && fetch_en) begin
      m_want_req <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("req_valid", 32'(imem_req_valid), 32'(m_want_req));
      if (m_want_req) chk("req_addr", imem_req_addr, m_pc);
      chk("instruction", instruction, m_executing ? m_word : NOP);
      chk("retire", 32'(retire), 32'(m_executing));
      chk("pc", pc, m_pc);
      chk("retired_count", retired_count, m_cnt);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_halted));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered in REQ; leaves one cycle after EXEC.
  task automatic fetch_one(input logic [31:0] data, input logic [31:0] npc);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    cyc();
    imem_resp_valid = 1'b0;
    next_pc         = npc;
    chk("fetch_instr", instruction, data);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    rst = 1'b1;
    fetch_en = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    next_pc = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_count", retired_count, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);

    // First fetch: REQ, WAIT, EXEC on cycle 3
    fetch_en = 1'b1;
    imem_req_ready = 1'b1;
    cyc();
    chk("t1_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    cyc();
    chk("t1_wait_valid", 32'(imem_req_valid), 32'h0);
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0050_0093;
    cyc();
    chk("t1_instr", instruction, 32'h0050_0093);
    chk("t1_retire", 32'(retire), 32'h1);
    imem_resp_valid = 1'b0;
    next_pc = 32'h4;
    cyc();
    chk("t1_count", retired_count, 32'h1);
    chk("t1_next_addr", imem_req_addr, 32'h4);

    // Stall on ready then on response
    repeat (4) begin
      cyc();
      chk("stall_req_valid", 32'(imem_req_valid), 32'h1);
      chk("stall_req_addr", imem_req_addr, 32'h4);
      chk("stall_instr", instruction, NOP);
    end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("stall_wait_instr", instruction, NOP);
      chk("stall_wait_retire", 32'(retire), 32'h0);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h00A0_0113;
    cyc();
    chk("stall_instr_exec", instruction, 32'h00A0_0113);
    imem_resp_valid = 1'b0;
    next_pc = 32'h40;
    cyc();
    chk("stall_single_retire", 32'(retire), 32'h0);
    chk("branch_addr", imem_req_addr, 32'h40);
    chk("stall_count", retired_count, 32'h2);

    // PC wrap
    fetch_one(32'h1234_5678, 32'hFFFF_FFFC);
    chk("wrap_high_addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch_one(32'h8765_4321, 32'h0);
    chk("wrap_addr", imem_req_addr, 32'h0);
    chk("wrap_count", retired_count, 32'h4);

    // fetch_en dropped before EXEC, then spurious responses
    fetch_en = 1'b0;
    fetch_one(32'h0000_0113, 32'h8);
    chk("idle_req_valid", 32'(imem_req_valid), 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    repeat (3) begin
      cyc();
      chk("spur_idle_req", 32'(imem_req_valid), 32'h0);
      chk("spur_idle_instr", instruction, NOP);
    end
    fetch_en = 1'b1;
    cyc();
    cyc();
    chk("spur_req_valid", 32'(imem_req_valid), 32'h1);
    chk("spur_req_addr", imem_req_addr, 32'h8);
    imem_resp_valid = 1'b0;

    // Async reset during WAIT
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", instruction, NOP);
    chk("arst_count", retired_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Misaligned branch target
    cyc();
    fetch_one(32'h0000_0013, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", 32'(fetch_fault), 32'h1);
    chk("mis_pc", pc, 32'h42);
    repeat (3) begin
      cyc();
      chk("mis_halt_req", 32'(imem_req_valid), 32'h0);
      chk("mis_halt_retire", 32'(retire), 32'h0);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`else
    chk("mis_addr", imem_req_addr, 32'h40);
    chk("mis_req_valid", 32'(imem_req_valid), 32'h1);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      fetch_en        = ($urandom_range(0, 9) < 8);
      imem_req_ready  = ($urandom_range(0, 9) < 6);
      imem_resp_valid = ($urandom_range(0, 1) == 1);
      imem_resp_data  = $urandom;
      r = $urandom_range(0, 99);
      if (r < 70)      next_pc = m_pc + 32'd4;
      else if (r < 95) next_pc = $urandom & 32'hFFFF_FFFC;
      else             next_pc = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle RV32 core.
- Owns the architectural PC register and fetches from instruction memory over a valid/ready request plus valid response interface.
- Presents exactly one real instruction per fetched word to the core's instruction/pc inputs, and takes the core's next_pc at the retire edge.
- While the fetch is outstanding, the core is fed a NOP (addi x0,x0,0), so its register-file and memory writes are harmless during stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction presented while not in EXEC.
- CNT_WIDTH, 32, width of retired_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  when low, no new request is issued; an in-flight fetch completes normally.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word address to fetch; always equals pc, bits [1:0]=00.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction word.
- instruction  out  32  to core; the fetched word in EXEC, NOP_INSTR otherwise.
- pc  out  32  to core; current PC register.
- next_pc  in  32  from core; sampled only at the EXEC posedge.
- retire  out  1  high during the single EXEC cycle.
- retired_count  out  CNT_WIDTH  number of instructions retired since reset; wraps.
- fetch_fault  out  1  misaligned-target flag; see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, instr_q=NOP_INSTR, retired_count=0, fetch_fault=0.
  - imem_req_valid=0, retire=0.
- States:
  - IDLE: if fetch_en, go to REQ next cycle. Otherwise stay in IDLE.
  - REQ: imem_req_valid=1 and imem_req_addr=pc, both held stable until the cycle where valid&&ready. On that handshake, go to WAIT.
  - WAIT: imem_req_valid=0. When imem_resp_valid=1, instr_q<=imem_resp_data and go to EXEC.
  - EXEC: instruction=instr_q, retire=1. At the posedge: pc<=next_pc, retired_count+=1, and next state is REQ if fetch_en, else IDLE.
- Response handling:
  - imem_resp_valid outside WAIT is ignored; no data is latched.
  - At most one request is outstanding at any time.
- Output values outside EXEC: instruction=NOP_INSTR and retire=0 in IDLE, REQ and WAIT.
- Latency:
  - Best case is 3 cycles per instruction: REQ (ready=1) -> WAIT (resp same cycle) -> EXEC.
  - Each extra cycle of ready or resp delay adds one cycle.
- next_pc alignment: next_pc[1:0] is forced to 00 when loaded into pc, unless FETCH_MISALIGN_TRAP_EN is defined.
- Widths and wrap:
  - pc is 32-bit; 32'hFFFF_FFFC + 4 = 0 is produced by the core and loaded as-is.
  - retired_count wraps from all-ones to 0.
- fetch_en dropped:
  - In REQ with the request not yet accepted: the request is still completed; no abort.
  - In EXEC: the instruction retires, then the block goes to IDLE.
- Reset mid-operation: returns to IDLE immediately. Instruction memory shares rst, so no stale response follows reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- With the macro defined:
  - In EXEC, if next_pc[1:0]!=0, pc<=next_pc unmodified and fetch_fault<=1.
  - The block then enters HALT: NOP presented, no requests issued, retire=0.
  - HALT is left only by reset.
- Without the macro: the HALT state does not exist, fetch_fault is tied to 0, and low bits are forced to 00.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, EXEC, HALT);
  - the NOP_INSTR constant, RV32 addi x0,x0,0;
  - the default RESET_PC.
- No sub-module is natural. The FSM, PC register and counter are a single module.

Test Plan:
- Reset-to-first-retire: rst pulse, fetch_en=1, ready=1, resp one cycle after accept with data 32'h0050_0093 -> req_addr=0, instruction=32'h0050_0093 in EXEC cycle 3, retired_count=1.
- Stall: ready held low 4 cycles, resp delayed 3 cycles -> req_valid/addr stable throughout, instruction=32'h0000_0013 until EXEC, single retire pulse.
- Branch target: next_pc=32'h0000_0040 at EXEC -> following req_addr=32'h0000_0040. Wrap case: next_pc=32'h0000_0000 from pc=32'hFFFF_FFFC -> req_addr=0.
- Spurious response: resp_valid=1 in IDLE and in REQ -> instr_q unchanged, no state change. fetch_en=0 in EXEC -> IDLE, no further requests.
- Async reset during WAIT: assert rst mid-cycle -> req_valid=0, pc=RESET_PC, instruction=NOP immediately, without waiting for a clock edge.
- Misaligned target: next_pc=32'h0000_0042 -> with FETCH_MISALIGN_TRAP_EN, fetch_fault=1 and no further requests; without it, req_addr=32'h0000_0040.
